cam_lvds_align: RTL

Word-alignment controller that sits directly downstream of one camera's `cam_lvds_rx` deserializer, in the `rx_coreclock` domain. It watches the sensor's idle training word on all five lanes: four data lanes and the sync lane. It pulses the deserializer's per-lane `rx_bitslip_ctrl` until every lane matches, then presents polarity-corrected, aligned 40-bit words and an `aligned` flag to the pixel/frame logic. One instance per camera.

---
 rtl/cam_lvds_align_pkg.sv | 32 +++
 rtl/cam_lvds_align_if.sv | 24 ++
 rtl/cam_lane_align.sv | 103 ++++++++++
 rtl/cam_lvds_align.sv | 76 +++++++
 4 files changed

// File: rtl/cam_lvds_align_pkg.sv
// Shared constants, lane state type and helpers for camera LVDS word alignment.
// Imported by the interface, the per-lane aligner and the top level.
package cam_pkg;

  localparam int NUM_LANES = 5;
  localparam int LANE_W    = 8;
  localparam int BUS_W     = NUM_LANES * LANE_W;

  localparam logic [LANE_W-1:0] TRAIN_WORD_DFLT = 8'h3A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } lane_state_t;

  // Spread one inversion bit per lane across that lane's byte.
  function automatic logic [BUS_W-1:0] expand_mask(
    input logic [NUM_LANES-1:0] m
  );
    logic [BUS_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      r[i*LANE_W +: LANE_W] = {LANE_W{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/cam_lvds_align_if.sv
// Signal bundle between the deserializer/pixel logic and the aligner.
// The master side drives enable, PLL lock and raw data; the slave is the aligner.
interface cam_lvds_align_if;
  import cam_pkg::*;

  logic                 en;
  logic                 pll_locked;
  logic [BUS_W-1:0]     rxd;
  logic [NUM_LANES-1:0] bitslip;
  logic [BUS_W-1:0]     rxd_out;
  logic                 aligned;
  logic [NUM_LANES-1:0] fail;

  modport master (
    output en, pll_locked, rxd,
    input  bitslip, rxd_out, aligned, fail
  );

  modport slave (
    input  en, pll_locked, rxd,
    output bitslip, rxd_out, aligned, fail
  );

endinterface

// File: rtl/cam_lane_align.sv
// One lane's alignment FSM: settle, compare against the training word,
// bitslip on mismatch, lock after enough consecutive matches or give up.
module cam_lane_align
  import cam_pkg::*;
#(
  parameter logic [LANE_W-1:0] TRAIN_WORD    = TRAIN_WORD_DFLT,
  parameter bit                INV           = 1'b0,
  parameter int                SETTLE_CYCLES = 8,
  parameter int                MATCH_COUNT   = 16,
  parameter int                MAX_SLIPS     = 8
) (
  input  logic              c,
  input  logic              rst,
  input  logic              go,
  input  logic [LANE_W-1:0] word,
  output logic              bitslip,
  output logic              locked,
  output logic              failed
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
  localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);

  lane_state_t state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [7:0]  match_q, match_d;
  logic [3:0]  slip_q, slip_d;
  logic        bitslip_q, bitslip_d;
  logic        hit;

  assign hit = (word ^ {LANE_W{INV}}) == TRAIN_WORD;

  // Next-state and counter update; losing go aborts everything to IDLE.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    match_d   = match_q;
    slip_d    = slip_q;
    bitslip_d = 1'b0;
    if (!go) begin
      state_d  = ST_IDLE;
      settle_d = '0;
      match_d  = '0;
      slip_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_SETTLE;
          settle_d = '0;
          slip_d   = '0;
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d = ST_CHECK;
            match_d = '0;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end
        ST_CHECK: begin
          if (hit) begin
            match_d = match_q + 8'd1;
            if (match_q == MATCH_LAST) state_d = ST_LOCKED;
          end else if (slip_q < SLIP_MAX) begin
            state_d   = ST_SLIP;
            bitslip_d = 1'b1;
          end else begin
            state_d = ST_FAIL;
          end
        end
        ST_SLIP: begin
          slip_d   = slip_q + 4'd1;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
        default: ;
      endcase
    end
  end

  // Lane state, counters and the registered slip pulse.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      match_q   <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      bitslip_q <= bitslip_d;
    end
  end

  assign bitslip = bitslip_q;
  assign locked  = (state_q == ST_LOCKED);
  assign failed  = (state_q == ST_FAIL);

endmodule

// File: rtl/cam_lvds_align.sv
// Word-alignment controller for one camera's five LVDS lanes.
// Holds the PLL-lock synchronizer, per-lane aligners and output registers.
module cam_lvds_align
  import cam_pkg::*;
#(
  parameter logic [LANE_W-1:0]    TRAIN_WORD    = TRAIN_WORD_DFLT,
  parameter logic [NUM_LANES-1:0] INV_MASK      = 5'h00,
  parameter int                   SETTLE_CYCLES = 8,
  parameter int                   MATCH_COUNT   = 16,
  parameter int                   MAX_SLIPS     = 8
) (
  input logic             c,
  input logic             rst,
  cam_lvds_align_if.slave bus
);

  logic [1:0]           sync_q, sync_d;
  logic [BUS_W-1:0]     rxd_out_q, rxd_out_d;
  logic                 aligned_q, aligned_d;
  logic [NUM_LANES-1:0] fail_q, fail_d;
  logic                 locked_s;
  logic                 go;
  logic [NUM_LANES-1:0] lane_slip;
  logic [NUM_LANES-1:0] lane_locked;
  logic [NUM_LANES-1:0] lane_failed;

  assign locked_s = sync_q[1];
  assign go       = bus.en & locked_s;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    cam_lane_align #(
      .TRAIN_WORD   (TRAIN_WORD),
      .INV          (INV_MASK[i]),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .MATCH_COUNT  (MATCH_COUNT),
      .MAX_SLIPS    (MAX_SLIPS)
    ) u_lane (
      .c      (c),
      .rst    (rst),
      .go     (go),
      .word   (bus.rxd[i*LANE_W +: LANE_W]),
      .bitslip(lane_slip[i]),
      .locked (lane_locked[i]),
      .failed (lane_failed[i])
    );
  end

  // Status is gated by go so enable/lock loss clears it on the very next edge.
  always_comb begin
    sync_d    = {sync_q[0], bus.pll_locked};
    rxd_out_d = bus.rxd ^ expand_mask(INV_MASK);
    aligned_d = (&lane_locked) & go;
    fail_d    = lane_failed & {NUM_LANES{go}};
  end

  // Lock synchronizer, corrected data and status registers.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      rxd_out_q <= '0;
      aligned_q <= 1'b0;
      fail_q    <= '0;
    end else begin
      sync_q    <= sync_d;
      rxd_out_q <= rxd_out_d;
      aligned_q <= aligned_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.bitslip = lane_slip;
  assign bus.rxd_out = rxd_out_q;
  assign bus.aligned = aligned_q;
  assign bus.fail    = fail_q;

endmodule
